// File: rtl/prbs_lfsr_checker_pkg.sv
// Shared types and the Galois LFSR step function for the PRBS checker.
// Any file that needs the checker FSM states or the step function imports prbs_pkg.
package prbs_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  localparam int CNT_W    = 4;
  localparam int PERIOD_W = 16;
  localparam int STEP_MAX = 32;

  // One Galois LFSR step for widths up to STEP_MAX.
  // Bits above the LFSR width are forced to zero in the result.
  function automatic logic [STEP_MAX-1:0] lfsr_step(
    input logic [STEP_MAX-1:0] s,
    input int                  width,
    input logic [STEP_MAX-1:0] taps
  );
    logic [STEP_MAX-1:0] mask;
    logic [STEP_MAX-1:0] shifted;
    mask    = (width >= STEP_MAX) ? '1 : ((STEP_MAX'(1) << width) - STEP_MAX'(1));
    shifted = (s << 1) & mask;
    return s[width-1] ? (shifted ^ (taps & mask)) : shifted;
  endfunction

endpackage

// File: rtl/prbs_lfsr_checker_galois_step.sv
// Combinational next-state predictor for a Galois LFSR of parameterised width and taps.
module galois_step
  import prbs_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b0011
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state
);

  logic [STEP_MAX-1:0] step_wide;

  assign step_wide  = lfsr_step(STEP_MAX'(state), WIDTH, STEP_MAX'(TAPS));
  assign next_state = step_wide[WIDTH-1:0];

endmodule

// File: rtl/prbs_lfsr_checker.sv
// PRBS checker: predicts each sampled LFSR word from the previous one and tracks lock/errors.
// Optional sequence-length measurement is built when PRBS_CHK_PERIOD_EN is defined.
module prbs_lfsr_checker
  import prbs_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] TAPS        = 4'b0011,
  parameter int               LOCK_CNT    = 4,
  parameter int               LOSS_THRESH = 3,
  parameter int               ERR_W       = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              data_valid,
  input  logic              clear_cnt,
  output logic              locked,
  output logic              error,
  output logic [ERR_W-1:0]  err_count,
  output logic              stuck_zero,
  output logic [15:0]       period
);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_THRESH - 1);

  chk_state_t        state_reg;
  logic [WIDTH-1:0]  prev_reg;
  logic              have_prev_reg;
  logic [CNT_W-1:0]  good_cnt_reg;
  logic [CNT_W-1:0]  bad_cnt_reg;
  logic [ERR_W-1:0]  err_count_reg;
  logic              error_reg;
  logic              stuck_zero_reg;
  logic              locked_reg;

  logic [WIDTH-1:0]  predicted;
  logic              is_zero;
  logic              match;
  logic              mismatch;
  logic              enter_lock;
  logic              drop_lock;

  galois_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_predict (
    .state      (prev_reg),
    .next_state (predicted)
  );

  // A zero word is always a mismatch, even when it is the seeding sample.
  assign is_zero    = (data_in == '0);
  assign match      = have_prev_reg && (data_in == predicted) && !is_zero;
  assign mismatch   = have_prev_reg ? !match : is_zero;
  assign enter_lock = data_valid && (state_reg == HUNT) && match && (good_cnt_reg == LOCK_LAST);
  assign drop_lock  = data_valid && (state_reg == LOCKED) && mismatch && (bad_cnt_reg == LOSS_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= HUNT;
      prev_reg       <= '0;
      have_prev_reg  <= 1'b0;
      good_cnt_reg   <= '0;
      bad_cnt_reg    <= '0;
      err_count_reg  <= '0;
      error_reg      <= 1'b0;
      stuck_zero_reg <= 1'b0;
      locked_reg     <= 1'b0;
    end else begin
      error_reg <= 1'b0;
      if (data_valid) begin
        prev_reg      <= data_in;
        have_prev_reg <= 1'b1;
        error_reg     <= mismatch;
        if (is_zero) begin
          stuck_zero_reg <= 1'b1;
        end
        case (state_reg)
          HUNT: begin
            if (enter_lock) begin
              state_reg    <= LOCKED;
              locked_reg   <= 1'b1;
              good_cnt_reg <= '0;
              bad_cnt_reg  <= '0;
            end else if (match) begin
              good_cnt_reg <= good_cnt_reg + 1'b1;
            end else begin
              good_cnt_reg <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              bad_cnt_reg <= '0;
            end else begin
              if (err_count_reg != '1) begin
                err_count_reg <= err_count_reg + 1'b1;
              end
              if (drop_lock) begin
                state_reg    <= HUNT;
                locked_reg   <= 1'b0;
                good_cnt_reg <= '0;
                bad_cnt_reg  <= '0;
              end else begin
                bad_cnt_reg <= bad_cnt_reg + 1'b1;
              end
            end
          end
          default: begin
            state_reg  <= HUNT;
            locked_reg <= 1'b0;
          end
        endcase
      end
      // Clear has priority over a same-cycle increment.
      if (clear_cnt) begin
        err_count_reg <= '0;
      end
    end
  end

  assign locked     = locked_reg;
  assign error      = error_reg;
  assign err_count  = err_count_reg;
  assign stuck_zero = stuck_zero_reg;

`ifdef PRBS_CHK_PERIOD_EN
  logic [WIDTH-1:0]    ref_word_reg;
  logic [PERIOD_W-1:0] cycle_cnt_reg;
  logic [PERIOD_W-1:0] cycle_cnt_inc;
  logic [PERIOD_W-1:0] period_reg;

  assign cycle_cnt_inc = (cycle_cnt_reg == '1) ? cycle_cnt_reg : cycle_cnt_reg + 1'b1;

  // The reference word is the sample that caused lock; each recurrence closes one period.
  always_ff @(posedge clock) begin
    if (reset) begin
      ref_word_reg  <= '0;
      cycle_cnt_reg <= '0;
      period_reg    <= '0;
    end else if (enter_lock) begin
      ref_word_reg  <= data_in;
      cycle_cnt_reg <= '0;
    end else if (data_valid && (state_reg == LOCKED)) begin
      if (data_in == ref_word_reg) begin
        period_reg    <= cycle_cnt_inc;
        cycle_cnt_reg <= '0;
      end else begin
        cycle_cnt_reg <= cycle_cnt_inc;
      end
    end
  end

  assign period = period_reg;
`else
  assign period = '0;
`endif

endmodule

// File: tb/tb_prbs_lfsr_checker.sv
// Directed self-checking bench for prbs_lfsr_checker with default parameters (x^4+x+1).
// Define PRBS_CHK_PERIOD_EN at compile time to also exercise the period measurement.
module tb_prbs_lfsr_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  data_in = 4'h0;
  logic        data_valid = 1'b0;
  logic        clear_cnt = 1'b0;
  logic        locked;
  logic        error;
  logic [7:0]  err_count;
  logic        stuck_zero;
  logic [15:0] period;

  int errors = 0;
  int checks = 0;

  prbs_lfsr_checker dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .clear_cnt  (clear_cnt),
    .locked     (locked),
    .error      (error),
    .err_count  (err_count),
    .stuck_zero (stuck_zero),
    .period     (period)
  );

  always #5 clock = ~clock;

  // Apply one cycle of stimulus; outputs are observed 1 time unit after the edge.
  task automatic step(input logic v, input logic [3:0] d, input logic c);
    data_valid = v;
    data_in    = d;
    clear_cnt  = c;
    @(posedge clock);
    #1;
    data_valid = 1'b0;
    clear_cnt  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b1, 4'h5, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%0b exp=0", locked); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%0b exp=0", error); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err_count got=%0h exp=00", err_count); end
    checks++; if (stuck_zero !== 1'b0) begin errors++; $display("FAIL reset_stuck_zero got=%0b exp=0", stuck_zero); end
    checks++; if (period !== 16'h0) begin errors++; $display("FAIL reset_period got=%0d exp=0", period); end
    reset = 1'b0;
    $display("reset: locked=%0b error=%0b err_count=%0h", locked, error, err_count);
  endtask

  task automatic test_lock();
    logic [3:0] seq [6];
    seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6};
    for (int i = 0; i < 4; i++) step(1'b1, seq[i], 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got=%0b exp=0", locked); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL lock_error_mid got=%0b exp=0", error); end
    for (int i = 4; i < 6; i++) step(1'b1, seq[i], 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_locked got=%0b exp=1", locked); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL lock_error got=%0b exp=0", error); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL lock_err_count got=%0h exp=00", err_count); end
    $display("lock: locked=%0b err_count=%0h", locked, err_count);
  endtask

  task automatic test_single_error();
    step(1'b1, 4'hD, 1'b0);  // expected C
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL single_error_pulse got=%0b exp=1", error); end
    checks++; if (err_count !== 8'h01) begin errors++; $display("FAIL single_err_count1 got=%0h exp=01", err_count); end
    step(1'b1, 4'hB, 1'b0);  // successor of C, but prev is D
    checks++; if (err_count !== 8'h02) begin errors++; $display("FAIL single_err_count2 got=%0h exp=02", err_count); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked_mid got=%0b exp=1", locked); end
    step(1'b1, 4'h5, 1'b0);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL single_error_resume got=%0b exp=0", error); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked got=%0b exp=1", locked); end
    step(1'b1, 4'hA, 1'b0);
    step(1'b1, 4'h7, 1'b0);
    checks++; if (err_count !== 8'h02) begin errors++; $display("FAIL single_err_count_final got=%0h exp=02", err_count); end
    $display("single_error: locked=%0b err_count=%0h", locked, err_count);
  endtask

  task automatic test_idle();
    step(1'b1, 4'hE, 1'b1);  // match with clear
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL idle_clear got=%0h exp=00", err_count); end
    step(1'b1, 4'h3, 1'b0);  // mismatch: expected F
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL idle_pre_error got=%0b exp=1", error); end
    step(1'b0, 4'h0, 1'b0);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL idle_error_drop got=%0b exp=0", error); end
    checks++; if (stuck_zero !== 1'b0) begin errors++; $display("FAIL idle_zero_ignored got=%0b exp=0", stuck_zero); end
    checks++; if (err_count !== 8'h01) begin errors++; $display("FAIL idle_err_count got=%0h exp=01", err_count); end
    step(1'b1, 4'h6, 1'b0);  // prev held at 3 across the gap
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL idle_prev_held got=%0b exp=0", error); end
`ifndef PRBS_CHK_PERIOD_EN
    checks++; if (period !== 16'h0) begin errors++; $display("FAIL idle_period_tied got=%0d exp=0", period); end
`endif
    $display("idle: locked=%0b err_count=%0h", locked, err_count);
  endtask

  task automatic test_loss_of_lock();
    logic [7:0] exp_cnt [3];
    logic       exp_lock [3];
    exp_cnt  = '{8'h02, 8'h03, 8'h04};
    exp_lock = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'h5, 1'b0);
      checks++; if (err_count !== exp_cnt[i]) begin errors++; $display("FAIL loss_err_count%0d got=%0h exp=%0h", i, err_count, exp_cnt[i]); end
      checks++; if (locked !== exp_lock[i]) begin errors++; $display("FAIL loss_locked%0d got=%0b exp=%0b", i, locked, exp_lock[i]); end
    end
    step(1'b1, 4'h5, 1'b0);  // mismatch in HUNT is not counted
    checks++; if (err_count !== 8'h04) begin errors++; $display("FAIL loss_hunt_count got=%0h exp=04", err_count); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL loss_hunt_error got=%0b exp=1", error); end
    $display("loss_of_lock: locked=%0b err_count=%0h", locked, err_count);
  endtask

  task automatic test_stuck_zero();
    logic [3:0] seq [6];
    seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6};
    step(1'b1, 4'h0, 1'b0);
    checks++; if (stuck_zero !== 1'b1) begin errors++; $display("FAIL zero_stuck got=%0b exp=1", stuck_zero); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL zero_error got=%0b exp=1", error); end
    for (int i = 0; i < 6; i++) step(1'b1, seq[i], 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL zero_relock got=%0b exp=1", locked); end
    checks++; if (stuck_zero !== 1'b1) begin errors++; $display("FAIL zero_sticky got=%0b exp=1", stuck_zero); end
    checks++; if (err_count !== 8'h04) begin errors++; $display("FAIL zero_err_count got=%0h exp=04", err_count); end
    $display("stuck_zero: stuck_zero=%0b locked=%0b", stuck_zero, locked);
  endtask

  task automatic test_saturation();
    // Each D (expected 1 after 9, or C after 6) mismatches; each following 9 matches.
    for (int i = 0; i < 251; i++) begin
      step(1'b1, 4'hD, 1'b0);
      step(1'b1, 4'h9, 1'b0);
    end
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_reach got=%0h exp=ff", err_count); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_locked got=%0b exp=1", locked); end
    step(1'b1, 4'hD, 1'b0);
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_hold got=%0h exp=ff", err_count); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL sat_error got=%0b exp=1", error); end
    step(1'b1, 4'h9, 1'b0);
    step(1'b1, 4'hD, 1'b1);
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL sat_clear_wins got=%0h exp=00", err_count); end
    $display("saturation: err_count=%0h locked=%0b", err_count, locked);
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    step(1'b1, 4'h9, 1'b0);
    reset = 1'b0;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL midrst_locked got=%0b exp=0", locked); end
    checks++; if (stuck_zero !== 1'b0) begin errors++; $display("FAIL midrst_stuck got=%0b exp=0", stuck_zero); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL midrst_error got=%0b exp=0", error); end
    step(1'b1, 4'h5, 1'b0);  // seed only
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL midrst_seed got=%0b exp=0", error); end
    step(1'b1, 4'hA, 1'b0);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL midrst_match got=%0b exp=0", error); end
    $display("mid_reset: locked=%0b error=%0b", locked, error);
  endtask

`ifdef PRBS_CHK_PERIOD_EN
  task automatic test_period();
    logic [3:0] loop_seq [15];
    loop_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                 4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};
    reset = 1'b1;
    step(1'b0, 4'h0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 37; i++) begin
      step(1'b1, loop_seq[i % 15], 1'b0);
      if (i % 3 == 0) step(1'b0, 4'h0, 1'b0);
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL period_locked got=%0b exp=1", locked); end
    checks++; if (period !== 16'd15) begin errors++; $display("FAIL period_value got=%0d exp=15", period); end
    reset = 1'b1;
    step(1'b1, loop_seq[7], 1'b0);
    reset = 1'b0;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL period_rst_locked got=%0b exp=0", locked); end
    checks++; if (period !== 16'd0) begin errors++; $display("FAIL period_rst_value got=%0d exp=0", period); end
    $display("period: period=%0d locked=%0b", period, locked);
  endtask
`endif

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_idle();
    test_loss_of_lock();
    test_stuck_zero();
    test_saturation();
    test_mid_reset();
`ifdef PRBS_CHK_PERIOD_EN
    test_period();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
